// File: rtl/nasser_hadi_pkg.sv
// Shared definitions for the debounced A/B/C input conditioning stage:
// per-channel FSM encoding and default timing parameters.
package nasser_hadi_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } db_state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DB_CYCLES   = 4;

endpackage

// File: rtl/nasser_hadi_dbnc_ch.sv
// One debounce channel: synchronizer chain, debounce FSM with counter and
// registered output level; chg_p/wait_p flag the FSM's next-state outcome.
module nasser_hadi_dbnc_ch
   import nasser_hadi_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int CW          = $clog2(DB_CYCLES) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic q,
   output logic chg_p,
   output logic wait_p
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;
   db_state_t              state_reg;
   logic [CW-1:0]          cnt_reg;
   logic                   cnt_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      end
   end

   assign s        = sync_reg[SYNC_STAGES-1];
   assign cnt_done = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= STABLE_LO;
         cnt_reg   <= '0;
         q         <= 1'b0;
      end else begin
         case (state_reg)
            STABLE_LO: begin
               if (s) begin
                  state_reg <= WAIT_HI;
                  cnt_reg   <= CW'(1);
               end else begin
                  cnt_reg   <= '0;
               end
            end
            WAIT_HI: begin
               if (!s) begin
                  state_reg <= STABLE_LO;
                  cnt_reg   <= '0;
               end else if (cnt_done) begin
                  state_reg <= STABLE_HI;
                  cnt_reg   <= '0;
                  q         <= 1'b1;
               end else begin
                  cnt_reg   <= cnt_reg + CW'(1);
               end
            end
            STABLE_HI: begin
               if (!s) begin
                  state_reg <= WAIT_LO;
                  cnt_reg   <= CW'(1);
               end else begin
                  cnt_reg   <= '0;
               end
            end
            WAIT_LO: begin
               if (s) begin
                  state_reg <= STABLE_HI;
                  cnt_reg   <= '0;
               end else if (cnt_done) begin
                  state_reg <= STABLE_LO;
                  cnt_reg   <= '0;
                  q         <= 1'b0;
               end else begin
                  cnt_reg   <= cnt_reg + CW'(1);
               end
            end
            default: begin
               state_reg <= STABLE_LO;
               cnt_reg   <= '0;
               q         <= 1'b0;
            end
         endcase
      end
   end

   // Flags describe the edge about to happen so the top can register them in
   // step with q and the state itself.
   assign chg_p  = ((state_reg == WAIT_HI) &&  s && cnt_done) ||
                   ((state_reg == WAIT_LO) && !s && cnt_done);
   assign wait_p = ((state_reg == STABLE_LO) &&  s) ||
                   ((state_reg == STABLE_HI) && !s) ||
                   ((state_reg == WAIT_HI)   &&  s && !cnt_done) ||
                   ((state_reg == WAIT_LO)   && !s && !cnt_done);

endmodule

// File: rtl/tt_um_nasser_hadi_dbnc.sv
// Three independent debounce channels for the A/B/C pipeline inputs, with a
// registered any-change strobe and any-channel-waiting indicator.
module tt_um_nasser_hadi_dbnc
   import nasser_hadi_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int CW          = $clog2(DB_CYCLES) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a_raw,
   input  logic b_raw,
   input  logic c_raw,
   output logic A,
   output logic B,
   output logic C,
   output logic chg,
   output logic busy
);

   logic [2:0] raw_vec;
   logic [2:0] q_vec;
   logic [2:0] chg_vec;
   logic [2:0] wait_vec;

   assign raw_vec = {c_raw, b_raw, a_raw};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ch
         nasser_hadi_dbnc_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES),
            .CW         (CW)
         ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_vec[gi]),
            .q     (q_vec[gi]),
            .chg_p (chg_vec[gi]),
            .wait_p(wait_vec[gi])
         );
      end
   endgenerate

   assign A = q_vec[0];
   assign B = q_vec[1];
   assign C = q_vec[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chg  <= 1'b0;
         busy <= 1'b0;
      end else begin
         chg  <= |chg_vec;
         busy <= |wait_vec;
      end
   end

endmodule

// File: tb/tb_tt_um_nasser_hadi_dbnc.sv
// Scoreboarded bench: a sliding-window debounce model predicts outputs every
// edge; a monitor compares them; directed scenarios then random bouncing.
module tb_tt_um_nasser_hadi_dbnc;

   localparam int SYNC = 2;
   localparam int DB   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic a_raw = 1'b0;
   logic b_raw = 1'b0;
   logic c_raw = 1'b0;
   logic A, B, C, chg, busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [4:0] exp_q[$];

   // Model: raw history feeds the FSM's view of s; an output flips at the
   // first edge whose last DB samples of s all disagree with it.
   bit       rawh[3][SYNC];
   bit       sh[3][DB];
   bit [2:0] out_m;

   tt_um_nasser_hadi_dbnc #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw),
      .A(A), .B(B), .C(C), .chg(chg), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      bit [2:0] raw_now;
      bit       samp, flip, chg_m, busy_m;
      raw_now = {c_raw, b_raw, a_raw};
      chg_m   = 1'b0;
      busy_m  = 1'b0;
      if (!rst_n) begin
         for (int ch = 0; ch < 3; ch++) begin
            for (int i = 0; i < SYNC; i++) rawh[ch][i] = 1'b0;
            for (int i = 0; i < DB; i++)   sh[ch][i]   = 1'b0;
         end
         out_m = 3'b000;
      end else begin
         for (int ch = 0; ch < 3; ch++) begin
            samp = rawh[ch][SYNC-1];
            for (int i = SYNC-1; i > 0; i--) rawh[ch][i] = rawh[ch][i-1];
            rawh[ch][0] = raw_now[ch];
            for (int i = DB-1; i > 0; i--) sh[ch][i] = sh[ch][i-1];
            sh[ch][0] = samp;
            flip = 1'b1;
            for (int i = 0; i < DB; i++)
               if (sh[ch][i] == out_m[ch]) flip = 1'b0;
            if (flip) begin
               out_m[ch] = ~out_m[ch];
               chg_m     = 1'b1;
            end
            if (samp != out_m[ch]) busy_m = 1'b1;
         end
      end
      exp_q.push_back({out_m, chg_m, busy_m});
   endtask

   initial begin : model_proc
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin : monitor_proc
      logic [4:0] got, e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         got = {C, B, A, chg, busy};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty cyc=%0d got {C,B,A,chg,busy}=%b", cyc, got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL outputs cyc=%0d got {C,B,A,chg,busy}=%b exp=%b", cyc, got, e);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spot(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", name, got, exp);
      end
   endtask

   initial begin : stim_proc
      int hold[3];
      bit [2:0] lvl;
      // Pins high throughout reset, then released.
      @(negedge clk);
      a_raw = 1'b1; b_raw = 1'b1; c_raw = 1'b1;
      step(4);
      rst_n = 1'b1;
      step(10);
      a_raw = 1'b0; b_raw = 1'b0; c_raw = 1'b0;
      step(10);

      // Clean rising edge with an independent latency spot check (edge k+5).
      a_raw = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      spot("rise_a_before_k5", A, 1'b0);
      spot("busy_during_wait", busy, 1'b1);
      @(posedge clk);
      #1;
      spot("rise_a_at_k5", A, 1'b1);
      spot("chg_at_k5", chg, 1'b1);
      @(posedge clk);
      #1;
      spot("chg_one_cycle", chg, 1'b0);
      spot("busy_cleared", busy, 1'b0);
      step(6);
      a_raw = 1'b0;
      step(10);

      // Glitch of DB-1 cycles on B.
      b_raw = 1'b1; step(3); b_raw = 1'b0; step(10);

      // Bounce train on C.
      c_raw = 1'b1; step(1); c_raw = 1'b0; step(1);
      c_raw = 1'b1; step(2); c_raw = 1'b0; step(1);
      c_raw = 1'b1; step(10);
      c_raw = 1'b0; step(10);

      // Simultaneous A and C.
      a_raw = 1'b1; c_raw = 1'b1; step(10);
      a_raw = 1'b0; c_raw = 1'b0; step(10);

      // Reset two cycles into WAIT_HI on B, then full-latency debounce.
      b_raw = 1'b1; step(4);
      rst_n = 1'b0; step(2);
      rst_n = 1'b1; step(12);
      b_raw = 1'b0; step(10);

      // Random bouncing with varied hold lengths and occasional resets.
      for (int ch = 0; ch < 3; ch++) hold[ch] = 1;
      lvl = 3'b000;
      for (int n = 0; n < 3000; n++) begin
         for (int ch = 0; ch < 3; ch++) begin
            hold[ch]--;
            if (hold[ch] <= 0) begin
               lvl[ch]  = ~lvl[ch];
               hold[ch] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3)
                                                      : $urandom_range(3, 9);
            end
         end
         a_raw = lvl[0]; b_raw = lvl[1]; c_raw = lvl[2];
         if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
         step(1);
      end
      rst_n = 1'b1;
      a_raw = 1'b0; b_raw = 1'b0; c_raw = 1'b0;
      step(12);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
